texel_serializer: RTL and testbench
===================================

# texel_serializer

Transmit-side counterpart of the texel assembler. Takes one 168-bit texel from the texture pipeline and emits it as a framed stream of 32-bit words into the AHB master's write buffer. Frame format: FRAME_START, one header word, five payload words, FRAME_END. Frames are pushed one word per cycle, and the block stalls on write-buffer backpressure.

## Interface
- FRAME_START, default 32'd0: first word of every frame.
- FRAME_END, default 32'd1: last word of every frame.
- clk  input  1: system clock; all state updates on the rising edge.
- n_rst  input  1: synchronous, active-low reset, sampled on the rising edge of clk.
- texel_buffer  input  168: texel to send; sampled only on an accept cycle.
- texel_valid  input  1: producer has a texel on texel_buffer.
- ahb_buffer_full  input  1: AHB write buffer cannot take a word this cycle.
- texel_accept  output  1: texel_buffer is captured at this rising edge.
- ahb_buffer  output  32: word presented to the AHB write buffer.
- ahb_user_write_buffer  output  1: push strobe; a word transfers on each rising edge where this is high.
- busy  output  1: a frame is in progress (state != IDLE).

## Operation
- Holding register: 168-bit texel_q. It is loaded only on accept.
- States and the word each presents on ahb_buffer:
  - IDLE: 32'd0.
  - START: FRAME_START.
  - HDR: {24'd0, texel_q[167:160]}.
  - DATA: payload word selected by 3-bit counter idx, 0..4. Word idx is texel_q[159-32*idx -: 32], so bits [159:128] are sent first and bits [31:0] last.
  - (CHK when compiled in, see Configuration.)
  - END: FRAME_END.
- texel_accept = (state==IDLE) & texel_valid. It is combinational from registered state.
- On accept: texel_q <= texel_buffer, idx <= 0, state <= START.
- ahb_user_write_buffer = (state != IDLE) & ~ahb_buffer_full.
- A state advances only on an edge where ahb_user_write_buffer is high.
- Transitions on a push:
  - START -> HDR -> DATA.
  - DATA: idx increments. At idx==4 go to END (or CHK), and idx wraps to 0.
  - END -> IDLE.
- ahb_buffer_full high: state, idx and ahb_buffer hold. No word is dropped or duplicated.
- texel_valid is ignored outside IDLE. texel_buffer may change freely after accept.
- Reset values:
  - texel_accept 0 when texel_valid is low; it follows texel_valid because state is IDLE.
  - ahb_buffer 32'd0, ahb_user_write_buffer 0, busy 0.
  - state IDLE, idx 0, texel_q 0.
- Reset mid-frame: the frame is abandoned with no FRAME_END word. The latched texel is discarded. At the next edge all outputs take their reset values.

## Timing
- Accept at edge k. FRAME_START is presented during cycle k+1 and pushed at edge k+1 if not full.
- With no backpressure:
  - 8 words pushed on edges k+1..k+8.
  - busy is high for cycles k+1..k+8.
  - IDLE is re-entered at edge k+8, so texel_accept can next occur at edge k+9.
- Minimum frame spacing: 9 cycles (10 with CHK compiled in).
- Each cycle of ahb_buffer_full adds exactly one cycle of latency.
- ahb_buffer_full going high in END state delays the return to IDLE, and therefore delays the next accept.
- ahb_buffer_full is ignored in IDLE.

## Configuration
- Macro: TEXEL_SERIALIZER_CHECKSUM_EN.
- When defined:
  - State CHK is inserted between the last DATA word and END.
  - CHK presents the XOR of the header word and all five payload words.
  - Frame length is 9 words.
- When undefined:
  - CHK does not exist and the frame is 8 words.
  - No other logic differs.

## Test plan
- Reset, texel_valid=0:
  - ahb_user_write_buffer=0, busy=0, ahb_buffer=0, texel_accept=0.
- Single texel with payload words 1,2,3,4,5 MSB-first and header 8'hA5, full=0:
  - Accept for one cycle.
  - Pushes on 8 consecutive edges: 0, 32'hA5, 1, 2, 3, 4, 5, 1.
  - busy falls after the last push.
- Same texel with ahb_buffer_full high for 3 cycles while word 3 is presented:
  - ahb_buffer holds 3 and strobe is low for those cycles.
  - Sequence otherwise identical; total length 11 cycles.
- texel_valid held high, two texels:
  - Second accept occurs exactly 9 cycles after the first.
  - Changing texel_buffer mid-frame does not alter the words sent.
- n_rst asserted while the DATA word at idx=2 is presented:
  - Next edge: busy=0, no further pushes, no FRAME_END.
  - A new texel afterwards sends a complete, correct frame.
- With TEXEL_SERIALIZER_CHECKSUM_EN and the texel above:
  - 9th-from-start word is 32'hA5^1^2^3^4^5 = 32'hA4, followed by FRAME_END.

Source files
------------

// File: rtl/texel_serializer.sv
// ---------------------------------------------------------------------------
// texel_serializer
//
// Purpose:
//    Takes one 168-bit texel from the texture pipeline and emits it as a framed
//    stream of 32-bit words into the AHB master's write buffer:
//       FRAME_START, header {24'd0, texel[167:160]}, five payload words
//       (texel[159:128] first, texel[31:0] last), FRAME_END.
//    One word is pushed per cycle. The block stalls while the write buffer
//    reports full.
//
// Optional feature:
//    TEXEL_SERIALIZER_CHECKSUM_EN - when defined, a checksum word (XOR of the
//    header and all five payload words) is inserted between the last payload
//    word and FRAME_END, giving a 9-word frame instead of 8.
//
// Parameters:
//    FRAME_START - first word of every frame (default 32'd0)
//    FRAME_END   - last word of every frame  (default 32'd1)
//
// Ports:
//    clk                   in   system clock, rising edge
//    n_rst                 in   synchronous active-low reset
//    texel_buffer [167:0]  in   texel to send, captured on an accept edge
//    texel_valid           in   producer has a texel on texel_buffer
//    ahb_buffer_full       in   write buffer cannot take a word this cycle
//    texel_accept          out  texel_buffer is captured at this edge
//    ahb_buffer [31:0]     out  word presented to the write buffer
//    ahb_user_write_buffer out  push strobe, one word per high edge
//    busy                  out  a frame is in progress
// ---------------------------------------------------------------------------
module texel_serializer #(
   parameter logic [31:0] FRAME_START = 32'd0,
   parameter logic [31:0] FRAME_END   = 32'd1
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic [167:0] texel_buffer,
   input  logic         texel_valid,
   input  logic         ahb_buffer_full,
   output logic         texel_accept,
   output logic [31:0]  ahb_buffer,
   output logic         ahb_user_write_buffer,
   output logic         busy
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_HDR   = 3'd2,
      ST_DATA  = 3'd3,
      ST_CHK   = 3'd4,
      ST_END   = 3'd5
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'd4;

   state_t         state_r;
   state_t         state_next_s;
   logic [2:0]     idx_r;
   logic [2:0]     idx_next_s;
   logic [167:0]   texel_q_r;
   logic [167:0]   texel_next_s;
   logic [31:0]    ahb_buffer_r;
   logic [31:0]    word_next_s;
   logic           busy_r;
   logic           busy_next_s;
   logic           push_s;
   logic           accept_s;

   // Payload word idx of a texel; word 0 is the most significant slice.
   function automatic logic [31:0] payload_word(input logic [167:0] texel,
                                                input logic [2:0]   idx);
      logic [31:0] word;
      case (idx)
         3'd0:    word = texel[159:128];
         3'd1:    word = texel[127:96];
         3'd2:    word = texel[95:64];
         3'd3:    word = texel[63:32];
         3'd4:    word = texel[31:0];
         default: word = 32'd0;
      endcase
      return word;
   endfunction

   // Header word carries the top byte of the texel, zero-extended.
   function automatic logic [31:0] header_word(input logic [167:0] texel);
      return {24'd0, texel[167:160]};
   endfunction

`ifdef TEXEL_SERIALIZER_CHECKSUM_EN
   // XOR checksum over the header and all five payload words.
   function automatic logic [31:0] frame_checksum(input logic [167:0] texel);
      return header_word(texel) ^ texel[159:128] ^ texel[127:96] ^
             texel[95:64] ^ texel[63:32] ^ texel[31:0];
   endfunction
`endif

   // Word presented on the bus for a given state/idx/texel combination.
   function automatic logic [31:0] word_of(input state_t       st,
                                           input logic [2:0]   idx,
                                           input logic [167:0] texel);
      logic [31:0] word;
      case (st)
         ST_IDLE:  word = 32'd0;
         ST_START: word = FRAME_START;
         ST_HDR:   word = header_word(texel);
         ST_DATA:  word = payload_word(texel, idx);
`ifdef TEXEL_SERIALIZER_CHECKSUM_EN
         ST_CHK:   word = frame_checksum(texel);
`endif
         ST_END:   word = FRAME_END;
         default:  word = 32'd0;
      endcase
      return word;
   endfunction

   // Handshake strobes decoded from registered state and the live inputs.
   always_comb begin
      accept_s = (state_r == ST_IDLE) & texel_valid;
      push_s   = (state_r != ST_IDLE) & ~ahb_buffer_full;
   end

   assign texel_accept          = accept_s;
   assign ahb_user_write_buffer = push_s;
   assign ahb_buffer            = ahb_buffer_r;
   assign busy                  = busy_r;

   // State register plus registered outputs; reset discards any frame in flight.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_r      <= ST_IDLE;
         idx_r        <= 3'd0;
         texel_q_r    <= 168'd0;
         ahb_buffer_r <= 32'd0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         idx_r        <= idx_next_s;
         texel_q_r    <= texel_next_s;
         ahb_buffer_r <= word_next_s;
         busy_r       <= busy_next_s;
      end
   end

   // Next-state logic: every non-idle state only advances on a push edge.
   always_comb begin
      state_next_s = state_r;
      idx_next_s   = idx_r;
      texel_next_s = texel_q_r;
      case (state_r)
         ST_IDLE: begin
            if (texel_valid) begin
               state_next_s = ST_START;
               idx_next_s   = 3'd0;
               texel_next_s = texel_buffer;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (push_s) begin
               state_next_s = ST_HDR;
            end else begin
               state_next_s = ST_START;
            end
         end
         ST_HDR: begin
            if (push_s) begin
               state_next_s = ST_DATA;
            end else begin
               state_next_s = ST_HDR;
            end
         end
         ST_DATA: begin
            if (push_s) begin
               if (idx_r == LAST_IDX) begin
                  idx_next_s = 3'd0;
`ifdef TEXEL_SERIALIZER_CHECKSUM_EN
                  state_next_s = ST_CHK;
`else
                  state_next_s = ST_END;
`endif
               end else begin
                  idx_next_s = idx_r + 3'd1;
               end
            end else begin
               state_next_s = ST_DATA;
            end
         end
`ifdef TEXEL_SERIALIZER_CHECKSUM_EN
         ST_CHK: begin
            if (push_s) begin
               state_next_s = ST_END;
            end else begin
               state_next_s = ST_CHK;
            end
         end
`endif
         ST_END: begin
            if (push_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_END;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            idx_next_s   = 3'd0;
         end
      endcase
   end

   // Output logic: precompute the word and busy flag of the next state so
   // that both outputs come straight from flops.
   always_comb begin
      word_next_s = word_of(state_next_s, idx_next_s, texel_next_s);
      busy_next_s = (state_next_s != ST_IDLE);
   end

endmodule

// File: tb/tb_texel_serializer.sv
// ---------------------------------------------------------------------------
// tb_texel_serializer
//
// Self-checking bench for texel_serializer. A frame-level model keeps a
// queue of the words still owed to the write buffer; every accepted texel
// appends its whole frame. A compare process checks all outputs against that
// queue every cycle. Directed tests pin the model with literal frames.
// Define TEXEL_SERIALIZER_CHECKSUM_EN for both bench and RTL together.
// ---------------------------------------------------------------------------
module tb_texel_serializer;

`ifdef TEXEL_SERIALIZER_CHECKSUM_EN
   localparam int FRAME_LEN = 9;
`else
   localparam int FRAME_LEN = 8;
`endif

   logic         tb_clk = 1'b0;
   logic         n_rst;
   logic [167:0] texel_buffer;
   logic         texel_valid;
   logic         ahb_buffer_full;
   logic         texel_accept;
   logic [31:0]  ahb_buffer;
   logic         ahb_user_write_buffer;
   logic         busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit check_en = 1'b0;

   logic [31:0] exp_q [$];   // words still owed by the DUT
   logic [31:0] log_q [$];   // words actually pushed
   int          acc_q [$];   // cycle numbers of accepts

   texel_serializer dut (
      .clk                   (tb_clk),
      .n_rst                 (n_rst),
      .texel_buffer          (texel_buffer),
      .texel_valid           (texel_valid),
      .ahb_buffer_full       (ahb_buffer_full),
      .texel_accept          (texel_accept),
      .ahb_buffer            (ahb_buffer),
      .ahb_user_write_buffer (ahb_user_write_buffer),
      .busy                  (busy)
   );

   always #5 tb_clk = ~tb_clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Whole frame for one texel, built directly from the frame format.
   task automatic push_frame(input logic [167:0] t);
      logic [31:0] w;
      logic [31:0] sum;
      exp_q.push_back(32'd0);
      sum = {24'd0, t[167:160]};
      exp_q.push_back(sum);
      for (int i = 0; i < 5; i++) begin
         w = t[159 - 32*i -: 32];
         sum = sum ^ w;
         exp_q.push_back(w);
      end
`ifdef TEXEL_SERIALIZER_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
      exp_q.push_back(32'd1);
   endtask

   // Per-cycle compare against the model, sampled mid-cycle.
   always @(negedge tb_clk) begin
      logic exp_busy;
      cyc++;
      if (check_en) begin
         exp_busy = (exp_q.size() != 0);
         check1("accept", texel_accept, !exp_busy && texel_valid);
         check1("busy", busy, exp_busy);
         check1("strobe", ahb_user_write_buffer, exp_busy && !ahb_buffer_full);
         check32("word", ahb_buffer, exp_busy ? exp_q[0] : 32'd0);
         if (ahb_user_write_buffer === 1'b1) begin
            log_q.push_back(ahb_buffer);
            if (exp_busy) void'(exp_q.pop_front());
         end
         if (!n_rst) begin
            exp_q.delete();
         end else if (!exp_busy && texel_valid) begin
            push_frame(texel_buffer);
            acc_q.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (n >= 200) begin
         bad++;
         $display("FAIL %s: timeout waiting for idle, got busy=%b expected 0", name, busy);
      end
   endtask

   task automatic check_log_literal(input string name);
      logic [31:0] lit [0:8];
      lit[0] = 32'd0; lit[1] = 32'hA5; lit[2] = 32'd1; lit[3] = 32'd2;
      lit[4] = 32'd3; lit[5] = 32'd4;  lit[6] = 32'd5;
`ifdef TEXEL_SERIALIZER_CHECKSUM_EN
      lit[7] = 32'hA4; lit[8] = 32'd1;
`else
      lit[7] = 32'd1;  lit[8] = 32'd0;
`endif
      check32({name, "_len"}, log_q.size(), FRAME_LEN);
      for (int i = 0; i < FRAME_LEN; i++) begin
         check32($sformatf("%s_w%0d", name, i),
                 (i < log_q.size()) ? log_q[i] : 32'hDEADBEEF, lit[i]);
      end
   endtask

   // Accept one texel, optionally stall 3 cycles on word 3, return busy length.
   task automatic send_one(input logic [167:0] t, input bit stall, output int len);
      int n = 0;
      texel_buffer = t;
      texel_valid  = 1'b1;
      tick();
      texel_valid  = 1'b0;
      texel_buffer = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      while (busy === 1'b1 && n < 200) begin
         if (stall && n == 4) ahb_buffer_full = 1'b1;
         if (n == 7) ahb_buffer_full = 1'b0;
         if (stall && n >= 4 && n < 7) begin
            #1;
            check32("stall_word", ahb_buffer, 32'd3);
            check1("stall_strobe", ahb_user_write_buffer, 1'b0);
         end
         tick();
         n++;
      end
      len = n;
   endtask

   localparam logic [167:0] TEX_A = {8'hA5, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};

   initial begin
      int len;
      n_rst           = 1'b0;
      texel_valid     = 1'b0;
      ahb_buffer_full = 1'b0;
      texel_buffer    = 168'd0;
      tick();
      tick();
      check_en = 1'b1;

      // Reset state
      check32("rst_word", ahb_buffer, 32'd0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_strobe", ahb_user_write_buffer, 1'b0);
      check1("rst_accept", texel_accept, 1'b0);
      texel_valid = 1'b1;
      #1;
      check1("rst_accept_follows", texel_accept, 1'b1);
      tick();
      texel_valid = 1'b0;
      n_rst = 1'b1;
      tick();

      // Single texel, no backpressure
      log_q.delete();
      send_one(TEX_A, 1'b0, len);
      check32("plain_len", len, FRAME_LEN);
      check_log_literal("plain");

      // Same texel, 3-cycle stall on word 3
      tick();
      log_q.delete();
      send_one(TEX_A, 1'b1, len);
      check32("stall_len", len, FRAME_LEN + 3);
      check_log_literal("stall");

      // valid held high, texel_buffer churning every cycle
      tick();
      acc_q.delete();
      texel_valid = 1'b1;
      for (int i = 0; i < 2 * FRAME_LEN + 4; i++) begin
         texel_buffer = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         tick();
      end
      texel_valid = 1'b0;
      wait_idle("b2b");
      total++;
      if (acc_q.size() < 2 || acc_q[1] - acc_q[0] != FRAME_LEN + 1) begin
         bad++;
         $display("FAIL b2b_spacing: got %0d expected %0d",
                  (acc_q.size() < 2) ? -1 : acc_q[1] - acc_q[0], FRAME_LEN + 1);
      end

      // Reset while payload idx 2 is presented
      tick();
      log_q.delete();
      texel_buffer = TEX_A;
      texel_valid  = 1'b1;
      tick();
      texel_valid  = 1'b0;
      repeat (4) tick();
      check32("mid_word", ahb_buffer, 32'd3);
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      check1("mid_busy", busy, 1'b0);
      check32("mid_out", ahb_buffer, 32'd0);
      check1("mid_strobe", ahb_user_write_buffer, 1'b0);
      repeat (3) tick();
      check32("mid_len", log_q.size(), 32'd5);
      log_q.delete();
      send_one(TEX_A, 1'b0, len);
      check_log_literal("after_rst");

      // Randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         texel_valid     = ($urandom_range(0, 2) == 0);
         ahb_buffer_full = ($urandom_range(0, 3) == 0);
         texel_buffer    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         tick();
      end
      texel_valid     = 1'b0;
      ahb_buffer_full = 1'b0;
      wait_idle("rand");
      check32("rand_drained", exp_q.size(), 32'd0);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
